octree_host_sequencer: RTL and testbench
========================================

Name: octree_host_sequencer

Overview:
Host-side initiator that drives the octree accelerator's CSR and in/out-SRAM test port. It accepts one command at a time and runs the full transaction:
- preload input words into the in/out SRAM;
- launch the search/add/delete op by producing a one-cycle csr_ctrl change;
- wait for the matching csr_op_done code, then acknowledge it;
- read back result words into a valid/ready stream;
- return a status response.

It sits between the SoC command bus/DMA and the accelerator top.

Parameters:
- ADDR_WIDTH, 10, in/out SRAM address width.
- DATA_WIDTH, 64, SRAM word width.
- ENCODE_ADDR_WIDTH, 14, pos_encode width (3*TREE_LEVEL+clog2(TREE_LEVEL)).
- IN_BASE, 0, first in/out SRAM address written during load.
- OUT_BASE, 10, first in/out SRAM address read during readback.
- SETTLE_CYCLES, 3, cycles csr_ctrl is held at 0 after launch before done is sampled.
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles before the op is aborted.

Ports:
- clk in 1: clock.
- rst in 1: synchronous reset, active-high.
- cmd_valid in 1 / cmd_ready out 1: command handshake.
- cmd_op in 2: 1 search, 2 add, 3 delete; 0 means a transfer-only command.
- cmd_pos_encode in ENCODE_ADDR_WIDTH: anchor position encode.
- cmd_load_len in ADDR_WIDTH: number of words to preload (0 allowed).
- cmd_read_len in ADDR_WIDTH: number of words to read back (0 allowed).
- ld_valid in 1 / ld_ready out 1 / ld_data in DATA_WIDTH: preload stream.
- rd_valid out 1 / rd_ready in 1 / rd_data out DATA_WIDTH: readback stream.
- rsp_valid out 1 / rsp_ready in 1 / rsp_status out 2: 0 ok, 1 timeout, 2 wrong done code.
- csr_ctrl out 2, csr_pos_encode out ENCODE_ADDR_WIDTH, csr_received_done out 1, csr_in_out_sram_en out 1.
- csr_op_done in 2: 1 search done, 2 add done, 3 delete done.
- axi_in_out_SRAM_req_o out 1, axi_in_out_SRAM_we_o out 1, axi_in_out_SRAM_addr_o out ADDR_WIDTH, axi_in_out_SRAM_wdata_o out DATA_WIDTH, axi_in_out_SRAM_rdata_i in DATA_WIDTH: the SRAM has 1-cycle read latency.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE; counters and the readback FIFO are cleared.
- Reset mid-operation aborts immediately. csr_ctrl drops to 0 the following cycle; no response is produced.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch op, pos_encode and lengths, and assert csr_pos_encode from the latched value.
  - Next state: LOAD if load_len>0; else LAUNCH if op!=0; else READ if read_len>0; else RESP.
- LOAD:
  - csr_in_out_sram_en=1 and ld_ready=1.
  - Each ld_valid&ld_ready cycle asserts req=1, we=1, addr=IN_BASE+idx, wdata=ld_data in the same cycle; idx increments.
  - Leave after load_len words. Addresses wrap mod 2^ADDR_WIDTH.
- LAUNCH:
  - One cycle: csr_in_out_sram_en=0, csr_ctrl=op.
  - Then SETTLE: csr_ctrl=0 for SETTLE_CYCLES. csr_op_done is not sampled in LAUNCH or SETTLE, so a stale done cannot be accepted.
  - csr_received_done is 0 throughout.
- WAIT:
  - Cycle counter increments each cycle.
  - csr_op_done==op: go to ACK with status 0.
  - csr_op_done nonzero and !=op: go to ACK with status 2.
  - Counter reaches TIMEOUT_CYCLES with no done: go to ACK with status 1.
  - If the matching done and the timeout occur in the same cycle, done wins.
- ACK: csr_received_done=1 for exactly one cycle. Next state is READ if read_len>0 and status==0, else RESP.
- READ:
  - csr_in_out_sram_en=1. Reads are issued with req=1, we=0, addr=OUT_BASE+idx.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2. At most 1 read is in flight.
  - rdata_i is captured into the 2-entry FIFO the cycle after issue; rd_valid = FIFO not empty.
  - Leave when read_len words have been issued, none are in flight, and the FIFO is empty.
  - Under rd_ready=0 the block stalls with no data loss; at full throughput it sustains 1 word/cycle.
- RESP:
  - rsp_valid=1 and held until rsp_ready; rsp_status is stable while rsp_valid=1.
  - csr_in_out_sram_en returns to 0. On handshake, go to IDLE.
- csr_ctrl is nonzero only in LAUNCH, which guarantees the accelerator sees exactly one ctrl edge per command.

Decomposition:
- Package octree_host_pkg: state enum (IDLE, LOAD, LAUNCH, SETTLE, WAIT, ACK, READ, RESP), op codes (NOP/SEARCH/ADD/DEL), status codes (OK/TIMEOUT/BADDONE).
- Sub-module octree_rd_fifo2: 2-entry valid/ready FIFO with a count output, used for readback.

Test Plan:
- Load-only: cmd_op=0, load_len=3, ld_data 0xA,0xB,0xC → writes to addresses 0,1,2; csr_ctrl stays 0; rsp_status=0.
- Search: op=1, read_len=4; model asserts csr_op_done=1 twenty cycles after the ctrl edge →
  - csr_ctrl=1 for exactly one cycle;
  - csr_received_done pulses once;
  - reads from addresses 10..13;
  - rd_data matches preset words; rsp_status=0.
- Readback backpressure: read_len=5 with rd_ready toggling 1,0,0,1 → all 5 words delivered in order, never more than 1 read in flight.
- Wrong code: op=2, model returns csr_op_done=3 → rsp_status=2, no READ phase.
- Timeout: op=3, no done → ACK at cycle TIMEOUT_CYCLES of WAIT; rsp_status=1.
- Reset mid-op: assert rst during WAIT → next cycle all outputs are at reset values, cmd_ready=1, and no response is produced.

Source files
------------

// File: rtl/octree_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : octree_host_pkg
// Description : Shared types and codes for the octree host sequencer:
//               sequencer state encoding, accelerator op codes and the
//               response status codes returned to the command issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package octree_host_pkg;

  // Sequencer states, one per phase of a command transaction
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAIT   = 3'd4,
    ST_ACK    = 3'd5,
    ST_READ   = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  // Accelerator op codes (also the matching csr_op_done codes)
  localparam logic [1:0] c_OP_NOP    = 2'd0;
  localparam logic [1:0] c_OP_SEARCH = 2'd1;
  localparam logic [1:0] c_OP_ADD    = 2'd2;
  localparam logic [1:0] c_OP_DEL    = 2'd3;

  // Response status codes
  localparam logic [1:0] c_STATUS_OK      = 2'd0;
  localparam logic [1:0] c_STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0] c_STATUS_BADDONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/octree_rd_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : octree_rd_fifo2
// Description : Two-entry valid/ready FIFO with an occupancy output, used to
//               buffer SRAM readback words ahead of the readback stream.
// Revision    : 1.0 - initial release
// ============================================================================
module octree_rd_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_pop;

  // A pop on an empty FIFO is ignored so the count can never underflow
  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Data storage; contents need no reset because the count gates validity
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/octree_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : octree_host_sequencer
// Description : Host-side initiator for the octree accelerator. Runs one
//               command at a time: preload in/out SRAM, launch the op with a
//               single csr_ctrl pulse, wait for and acknowledge the done code,
//               stream result words back and return a status response.
// Revision    : 1.0 - initial release
// ============================================================================
module octree_host_sequencer
  import octree_host_pkg::*;
#(
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_WIDTH        = 64,
  parameter int ENCODE_ADDR_WIDTH = 14,
  parameter int IN_BASE           = 0,
  parameter int OUT_BASE          = 10,
  parameter int SETTLE_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [1:0]                   i_cmd_op,
  input  logic [ENCODE_ADDR_WIDTH-1:0] i_cmd_pos_encode,
  input  logic [ADDR_WIDTH-1:0]        i_cmd_load_len,
  input  logic [ADDR_WIDTH-1:0]        i_cmd_read_len,
  input  logic                         i_ld_valid,
  output logic                         o_ld_ready,
  input  logic [DATA_WIDTH-1:0]        i_ld_data,
  output logic                         o_rd_valid,
  input  logic                         i_rd_ready,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [1:0]                   o_rsp_status,
  output logic [1:0]                   o_csr_ctrl,
  output logic [ENCODE_ADDR_WIDTH-1:0] o_csr_pos_encode,
  output logic                         o_csr_received_done,
  output logic                         o_csr_in_out_sram_en,
  input  logic [1:0]                   i_csr_op_done,
  output logic                         o_axi_in_out_sram_req,
  output logic                         o_axi_in_out_sram_we,
  output logic [ADDR_WIDTH-1:0]        o_axi_in_out_sram_addr,
  output logic [DATA_WIDTH-1:0]        o_axi_in_out_sram_wdata,
  input  logic [DATA_WIDTH-1:0]        i_axi_in_out_sram_rdata
);

  // One counter serves both SETTLE and WAIT, so it spans the larger bound
  localparam int                  c_CNT_W    = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] c_IN_BASE  = ADDR_WIDTH'(IN_BASE);
  localparam logic [ADDR_WIDTH-1:0] c_OUT_BASE = ADDR_WIDTH'(OUT_BASE);
  localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                         r_state;
  state_t                         w_next;
  logic [1:0]                     r_op;
  logic [ENCODE_ADDR_WIDTH-1:0]   r_pos;
  logic [ADDR_WIDTH-1:0]          r_load_len;
  logic [ADDR_WIDTH-1:0]          r_read_len;
  logic [ADDR_WIDTH-1:0]          r_idx;
  logic [ADDR_WIDTH-1:0]          w_idx_nxt;
  logic [c_CNT_W-1:0]             r_cnt;
  logic [c_CNT_W-1:0]             w_cnt_nxt;
  logic [1:0]                     r_status;
  logic [1:0]                     w_status_nxt;
  logic                           r_inflight;
  logic                           w_issue;
  logic                           w_cmd_fire;
  logic                           w_pop;
  logic [1:0]                     w_fifo_count;
  logic [2:0]                     w_occ;
  state_t                         w_after_load;

  // Readback buffer: the word returned by the SRAM is captured the cycle
  // after its read was issued
  octree_rd_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (i_axi_in_out_sram_rdata),
    .i_pop       (w_pop),
    .o_valid     (o_rd_valid),
    .o_data      (o_rd_data),
    .o_count     (w_fifo_count)
  );

  assign w_pop            = o_rd_valid & i_rd_ready;
  // Occupancy counts the pop happening this cycle so a drained slot can be
  // refilled immediately, which is what sustains one word per cycle
  assign w_occ            = {1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign o_csr_pos_encode = r_pos;
  assign w_after_load     = (r_op != c_OP_NOP)    ? ST_LAUNCH :
                            (r_read_len != '0)    ? ST_READ   : ST_RESP;

  // Next-state, counter updates and all phase-dependent outputs
  always_comb begin
    w_next                  = r_state;
    w_idx_nxt               = r_idx;
    w_cnt_nxt               = r_cnt;
    w_status_nxt            = r_status;
    w_cmd_fire              = 1'b0;
    w_issue                 = 1'b0;
    o_cmd_ready             = 1'b0;
    o_ld_ready              = 1'b0;
    o_rsp_valid             = 1'b0;
    o_rsp_status            = c_STATUS_OK;
    o_csr_ctrl              = c_OP_NOP;
    o_csr_received_done     = 1'b0;
    o_csr_in_out_sram_en    = 1'b0;
    o_axi_in_out_sram_req   = 1'b0;
    o_axi_in_out_sram_we    = 1'b0;
    o_axi_in_out_sram_addr  = '0;
    o_axi_in_out_sram_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_cmd_fire   = 1'b1;
          w_idx_nxt    = '0;
          w_cnt_nxt    = '0;
          w_status_nxt = c_STATUS_OK;
          if (i_cmd_load_len != '0)        w_next = ST_LOAD;
          else if (i_cmd_op != c_OP_NOP)   w_next = ST_LAUNCH;
          else if (i_cmd_read_len != '0)   w_next = ST_READ;
          else                             w_next = ST_RESP;
        end
      end
      ST_LOAD: begin
        o_csr_in_out_sram_en = 1'b1;
        o_ld_ready           = 1'b1;
        if (i_ld_valid) begin
          o_axi_in_out_sram_req   = 1'b1;
          o_axi_in_out_sram_we    = 1'b1;
          o_axi_in_out_sram_addr  = c_IN_BASE + r_idx;
          o_axi_in_out_sram_wdata = i_ld_data;
          if (r_idx == r_load_len - ADDR_WIDTH'(1)) begin
            w_idx_nxt = '0;
            w_next    = w_after_load;
          end else begin
            w_idx_nxt = r_idx + ADDR_WIDTH'(1);
          end
        end
      end
      ST_LAUNCH: begin
        o_csr_ctrl = r_op;
        w_cnt_nxt  = '0;
        w_next     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == c_SETTLE_LAST) begin
          w_cnt_nxt = '0;
          w_next    = ST_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // A matching done takes priority over a coincident timeout
        if (i_csr_op_done == r_op) begin
          w_status_nxt = c_STATUS_OK;
          w_next       = ST_ACK;
        end else if (i_csr_op_done != c_OP_NOP) begin
          w_status_nxt = c_STATUS_BADDONE;
          w_next       = ST_ACK;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_status_nxt = c_STATUS_TIMEOUT;
          w_next       = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_ACK: begin
        o_csr_received_done = 1'b1;
        w_idx_nxt           = '0;
        if ((r_read_len != '0) && (r_status == c_STATUS_OK)) w_next = ST_READ;
        else                                                 w_next = ST_RESP;
      end
      ST_READ: begin
        o_csr_in_out_sram_en = 1'b1;
        if ((r_idx != r_read_len) && (w_occ < 3'd2)) begin
          w_issue                = 1'b1;
          o_axi_in_out_sram_req  = 1'b1;
          o_axi_in_out_sram_addr = c_OUT_BASE + r_idx;
          w_idx_nxt              = r_idx + ADDR_WIDTH'(1);
        end
        if ((r_idx == r_read_len) && !r_inflight && (w_fifo_count == 2'd0)) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_status = r_status;
        if (i_rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, counters and latched command fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= c_OP_NOP;
      r_pos      <= '0;
      r_load_len <= '0;
      r_read_len <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_status   <= c_STATUS_OK;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_status   <= w_status_nxt;
      r_inflight <= w_issue;
      if (w_cmd_fire) begin
        r_op       <= i_cmd_op;
        r_pos      <= i_cmd_pos_encode;
        r_load_len <= i_cmd_load_len;
        r_read_len <= i_cmd_read_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_octree_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_octree_host_sequencer
// Description : Directed self-checking bench for octree_host_sequencer with a
//               1-cycle-latency SRAM model and a programmable done responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_octree_host_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [13:0] cmd_pos_encode = '0;
  logic [9:0]  cmd_load_len = '0;
  logic [9:0]  cmd_read_len = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [63:0] ld_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [1:0]  csr_ctrl;
  logic [13:0] csr_pos_encode;
  logic        csr_received_done;
  logic        csr_in_out_sram_en;
  logic [1:0]  csr_op_done = 2'd0;
  logic        sram_req;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata = '0;

  int checks = 0;
  int errors = 0;

  // done responder configuration
  bit         done_en = 1'b0;
  logic [1:0] done_code = 2'd0;
  int         done_delay = 20;
  int         done_cd = 0;

  // monitors
  int cyc = 0;
  int ctrl_cycles = 0;
  int last_ctrl_cyc = 0;
  int rcvd_cnt = 0;
  int last_rcvd_cyc = 0;
  int issued = 0;
  int delivered = 0;
  int out_viol = 0;
  logic [9:0]  wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  logic [9:0]  rd_addr_q[$];
  logic [63:0] rd_data_q[$];
  int          rd_cyc_q[$];
  logic [63:0] ld_words [8];

  logic [63:0] mem [1024];
  bit          wr_flag [1024];

  octree_host_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_cmd_valid             (cmd_valid),
    .o_cmd_ready             (cmd_ready),
    .i_cmd_op                (cmd_op),
    .i_cmd_pos_encode        (cmd_pos_encode),
    .i_cmd_load_len          (cmd_load_len),
    .i_cmd_read_len          (cmd_read_len),
    .i_ld_valid              (ld_valid),
    .o_ld_ready              (ld_ready),
    .i_ld_data               (ld_data),
    .o_rd_valid              (rd_valid),
    .i_rd_ready              (rd_ready),
    .o_rd_data               (rd_data),
    .o_rsp_valid             (rsp_valid),
    .i_rsp_ready             (rsp_ready),
    .o_rsp_status            (rsp_status),
    .o_csr_ctrl              (csr_ctrl),
    .o_csr_pos_encode        (csr_pos_encode),
    .o_csr_received_done     (csr_received_done),
    .o_csr_in_out_sram_en    (csr_in_out_sram_en),
    .i_csr_op_done           (csr_op_done),
    .o_axi_in_out_sram_req   (sram_req),
    .o_axi_in_out_sram_we    (sram_we),
    .o_axi_in_out_sram_addr  (sram_addr),
    .o_axi_in_out_sram_wdata (sram_wdata),
    .i_axi_in_out_sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // Default contents of never-written SRAM locations
  function automatic logic [63:0] exp_word(input logic [9:0] a);
    return 64'hD00D_0000_0000_0000 | {54'd0, a} | ({54'd0, a} << 20);
  endfunction

  // SRAM model with one cycle read latency, plus transaction monitors
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (sram_req && sram_we) begin
      mem[sram_addr]     <= sram_wdata;
      wr_flag[sram_addr] <= 1'b1;
    end
    if (sram_req && !sram_we) begin
      sram_rdata <= wr_flag[sram_addr] ? mem[sram_addr] : exp_word(sram_addr);
    end
    if (!rst) begin
      if (csr_ctrl != 2'd0) begin
        ctrl_cycles   = ctrl_cycles + 1;
        last_ctrl_cyc = cyc;
      end
      if (csr_received_done) begin
        rcvd_cnt      = rcvd_cnt + 1;
        last_rcvd_cyc = cyc;
      end
      if (sram_req && sram_we) begin
        wr_addr_q.push_back(sram_addr);
        wr_data_q.push_back(sram_wdata);
      end
      if (sram_req && !sram_we) begin
        rd_addr_q.push_back(sram_addr);
        issued = issued + 1;
      end
      if (rd_valid && rd_ready) begin
        rd_data_q.push_back(rd_data);
        rd_cyc_q.push_back(cyc);
        delivered = delivered + 1;
      end
      if (issued - delivered > 2) out_viol = out_viol + 1;
    end
  end

  // Accelerator done model: raise done_code done_delay cycles after the ctrl
  // pulse and hold it until the sequencer acknowledges
  always @(negedge clk) begin
    if (rst) begin
      done_cd     = 0;
      csr_op_done = 2'd0;
    end else begin
      if (csr_received_done) csr_op_done = 2'd0;
      if (csr_ctrl != 2'd0) begin
        if (done_en) done_cd = done_delay;
      end else if (done_cd > 0) begin
        done_cd = done_cd - 1;
        if (done_cd == 0) csr_op_done = done_code;
      end
    end
  end

  task automatic run_txn(input logic [1:0] op, input logic [13:0] pos,
                         input logic [9:0] ll, input logic [9:0] rl,
                         input logic [3:0] rdpat,
                         output logic [1:0] st, output bit got);
    int li;
    li  = 0;
    got = 1'b0;
    st  = 2'd0;
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_op         = op;
    cmd_pos_encode = pos;
    cmd_load_len   = ll;
    cmd_read_len   = rl;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 6000 && !got; c++) begin
      if (ld_ready && li < int'(ll)) begin
        ld_valid = 1'b1;
        ld_data  = ld_words[li];
        li++;
      end else begin
        ld_valid = 1'b0;
      end
      rd_ready = rdpat[c % 4];
      if (rsp_valid) begin
        st        = rsp_status;
        rsp_ready = 1'b1;
        got       = 1'b1;
      end
      @(negedge clk);
    end
    ld_valid  = 1'b0;
    rsp_ready = 1'b0;
    rd_ready  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (csr_ctrl !== 2'd0) begin errors++; $display("FAIL reset_csr_ctrl got %0d want 0", csr_ctrl); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got %b want 0", sram_req); end
    checks++; if (csr_pos_encode !== 14'd0) begin errors++; $display("FAIL reset_pos_encode got %h want 0", csr_pos_encode); end
    checks++; if (rd_valid !== 1'b0 || csr_received_done !== 1'b0 || csr_in_out_sram_en !== 1'b0) begin
      errors++; $display("FAIL reset_misc rd_valid=%b rcvd=%b en=%b want 0", rd_valid, csr_received_done, csr_in_out_sram_en);
    end
  endtask

  task automatic test_load_only();
    logic [1:0] st;
    bit got;
    int w0, c0;
    ld_words[0] = 64'hA; ld_words[1] = 64'hB; ld_words[2] = 64'hC;
    w0 = wr_addr_q.size();
    c0 = ctrl_cycles;
    run_txn(2'd0, 14'h123, 10'd3, 10'd0, 4'hF, st, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL load_rsp got %b want 1", got); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL load_status got %0d want 0", st); end
    checks++; if (wr_addr_q.size() - w0 != 3) begin errors++; $display("FAIL load_wr_count got %0d want 3", wr_addr_q.size() - w0); end
    for (int i = 0; i < 3 && w0 + i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[w0+i] !== 10'(i) || wr_data_q[w0+i] !== ld_words[i]) begin
        errors++; $display("FAIL load_write%0d got addr %0d data %h want addr %0d data %h", i, wr_addr_q[w0+i], wr_data_q[w0+i], i, ld_words[i]);
      end
    end
    checks++; if (ctrl_cycles != c0) begin errors++; $display("FAIL load_ctrl_cycles got %0d want 0", ctrl_cycles - c0); end
    checks++; if (csr_pos_encode !== 14'h123) begin errors++; $display("FAIL load_pos_encode got %h want 123", csr_pos_encode); end
  endtask

  task automatic test_search();
    logic [1:0] st;
    bit got;
    int r0, c0, k0, n;
    done_en = 1'b1; done_code = 2'd1; done_delay = 20;
    r0 = rd_addr_q.size(); c0 = ctrl_cycles; k0 = rcvd_cnt; n = rd_data_q.size();
    run_txn(2'd1, 14'h2A5, 10'd0, 10'd4, 4'hF, st, got);
    checks++; if (got !== 1'b1 || st !== 2'd0) begin errors++; $display("FAIL search_rsp got %b status %0d want 1 status 0", got, st); end
    checks++; if (ctrl_cycles - c0 != 1) begin errors++; $display("FAIL search_ctrl_cycles got %0d want 1", ctrl_cycles - c0); end
    checks++; if (rcvd_cnt - k0 != 1) begin errors++; $display("FAIL search_rcvd_pulses got %0d want 1", rcvd_cnt - k0); end
    checks++; if (rd_addr_q.size() - r0 != 4 || rd_data_q.size() - n != 4) begin
      errors++; $display("FAIL search_read_count got %0d/%0d want 4/4", rd_addr_q.size() - r0, rd_data_q.size() - n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rd_addr_q[r0+i] !== 10'(10 + i)) begin errors++; $display("FAIL search_rd_addr%0d got %0d want %0d", i, rd_addr_q[r0+i], 10 + i); end
        checks++; if (rd_data_q[n+i] !== exp_word(10'(10 + i))) begin errors++; $display("FAIL search_rd_data%0d got %h want %h", i, rd_data_q[n+i], exp_word(10'(10 + i))); end
      end
      checks++; if (rd_cyc_q[n+3] - rd_cyc_q[n] != 3) begin errors++; $display("FAIL search_throughput got span %0d want 3", rd_cyc_q[n+3] - rd_cyc_q[n]); end
    end
    done_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [1:0] st;
    bit got;
    int n, v0;
    n = rd_data_q.size(); v0 = out_viol;
    run_txn(2'd0, 14'h001, 10'd0, 10'd5, 4'b1001, st, got);
    checks++; if (got !== 1'b1 || st !== 2'd0) begin errors++; $display("FAIL bp_rsp got %b status %0d want 1 status 0", got, st); end
    checks++; if (rd_data_q.size() - n != 5) begin
      errors++; $display("FAIL bp_count got %0d want 5", rd_data_q.size() - n);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (rd_data_q[n+i] !== exp_word(10'(10 + i))) begin errors++; $display("FAIL bp_data%0d got %h want %h", i, rd_data_q[n+i], exp_word(10'(10 + i))); end
      end
    end
    checks++; if (out_viol != v0) begin errors++; $display("FAIL bp_outstanding got %0d cycles above 2 want 0", out_viol - v0); end
  endtask

  task automatic test_wrong_code();
    logic [1:0] st;
    bit got;
    int r0, k0;
    done_en = 1'b1; done_code = 2'd3; done_delay = 8;
    r0 = rd_addr_q.size(); k0 = rcvd_cnt;
    run_txn(2'd2, 14'h3FF, 10'd0, 10'd2, 4'hF, st, got);
    checks++; if (got !== 1'b1 || st !== 2'd2) begin errors++; $display("FAIL wrong_status got %b status %0d want 1 status 2", got, st); end
    checks++; if (rd_addr_q.size() != r0) begin errors++; $display("FAIL wrong_no_read got %0d reads want 0", rd_addr_q.size() - r0); end
    checks++; if (rcvd_cnt - k0 != 1) begin errors++; $display("FAIL wrong_rcvd_pulses got %0d want 1", rcvd_cnt - k0); end
    done_en = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] st;
    bit got;
    int r0, k0;
    done_en = 1'b0;
    r0 = rd_addr_q.size(); k0 = rcvd_cnt;
    run_txn(2'd3, 14'h0F0, 10'd0, 10'd1, 4'hF, st, got);
    checks++; if (got !== 1'b1 || st !== 2'd1) begin errors++; $display("FAIL timeout_status got %b status %0d want 1 status 1", got, st); end
    checks++; if (rcvd_cnt - k0 != 1) begin errors++; $display("FAIL timeout_rcvd_pulses got %0d want 1", rcvd_cnt - k0); end
    checks++; if (last_rcvd_cyc - last_ctrl_cyc != 4100) begin errors++; $display("FAIL timeout_latency got %0d want 4100", last_rcvd_cyc - last_ctrl_cyc); end
    checks++; if (rd_addr_q.size() != r0) begin errors++; $display("FAIL timeout_no_read got %0d reads want 0", rd_addr_q.size() - r0); end
  endtask

  task automatic test_zero_cmd();
    logic [1:0] st;
    bit got;
    int w0, r0;
    w0 = wr_addr_q.size(); r0 = rd_addr_q.size();
    run_txn(2'd0, 14'h055, 10'd0, 10'd0, 4'hF, st, got);
    checks++; if (got !== 1'b1 || st !== 2'd0) begin errors++; $display("FAIL zero_rsp got %b status %0d want 1 status 0", got, st); end
    checks++; if (wr_addr_q.size() != w0 || rd_addr_q.size() != r0) begin
      errors++; $display("FAIL zero_no_access got %0d writes %0d reads want 0 0", wr_addr_q.size() - w0, rd_addr_q.size() - r0);
    end
  endtask

  task automatic test_reset_mid_op();
    int rsp_seen;
    done_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_pos_encode = 14'h1AB; cmd_load_len = '0; cmd_read_len = 10'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || csr_ctrl !== 2'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs cmd_ready=%b ctrl=%0d rsp_valid=%b want 1 0 0", cmd_ready, csr_ctrl, rsp_valid);
    end
    checks++; if (csr_received_done !== 1'b0 || csr_in_out_sram_en !== 1'b0 || sram_req !== 1'b0 || csr_pos_encode !== 14'd0) begin
      errors++; $display("FAIL midrst_csr rcvd=%b en=%b req=%b pos=%h want 0 0 0 0", csr_received_done, csr_in_out_sram_en, sram_req, csr_pos_encode);
    end
    rsp_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    checks++; if (rsp_seen != 0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_no_rsp got %0d rsp cycles cmd_ready=%b want 0 1", rsp_seen, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_search();
    test_backpressure();
    test_wrong_code();
    test_timeout();
    test_zero_cmd();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
